// File: rtl/tattr_dma_ctrl_if.sv
// Bus bundle for tattr_dma_ctrl: CPU register port, CPU direct-store port,
// system-memory read port, vblank input and the tattr RAM write port.
// slave  = the DMA controller side, master = the surrounding system.
interface tattr_dma_ctrl_if #(
  parameter int ADDR_W   = 32,
  parameter int TATTR_AW = 10
);
  // register file access
  logic [1:0]          reg_addr;
  logic [31:0]         reg_wdata;
  logic                reg_wenable;
  logic [31:0]         reg_rdata;
  // CPU direct stores into tattr RAM
  logic [TATTR_AW-1:0] cpu_tattr_addr;
  logic [7:0]          cpu_tattr_wdata;
  logic                cpu_tattr_we;
  // system-memory source reads
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ready;
  logic [7:0]          mem_rdata;
  // display timing
  logic                vblank;
  // shared tattr RAM write port towards video_unit
  logic [TATTR_AW-1:0] tattr_addr;
  logic [7:0]          tattr_wdata;
  logic                tattr_wenable;
  // completion interrupt
  logic                done_irq;

  modport slave (
    input  reg_addr, reg_wdata, reg_wenable,
    input  cpu_tattr_addr, cpu_tattr_wdata, cpu_tattr_we,
    input  mem_ready, mem_rdata, vblank,
    output reg_rdata, mem_req, mem_addr,
    output tattr_addr, tattr_wdata, tattr_wenable, done_irq
  );

  modport master (
    output reg_addr, reg_wdata, reg_wenable,
    output cpu_tattr_addr, cpu_tattr_wdata, cpu_tattr_we,
    output mem_ready, mem_rdata, vblank,
    input  reg_rdata, mem_req, mem_addr,
    input  tattr_addr, tattr_wdata, tattr_wenable, done_irq
  );
endinterface

// File: rtl/tattr_dma_ctrl.sv
// tattr_dma_ctrl: byte-wise copy engine from system memory into tile-attribute
// RAM. Owns the single tattr write port; CPU direct stores always win it and
// the DMA write simply retries the next cycle.
// Optional feature: define TATTR_DMA_IRQ_EN to implement CTRL[3] irq_en and
// the registered done_irq pulse; otherwise done_irq is tied low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transfer; tattr port forwards CPU stores
// WAIT_VB | vb_only transfer waiting for vblank before the next byte
// READ    | mem_req held high at SRC until mem_ready, byte latched
// WRITE   | latched byte written at DST unless the CPU owns the port
module tattr_dma_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int TATTR_AW = 10,
  parameter int LEN_W    = 11
) (
  input logic           clk,
  input logic           rst,
  tattr_dma_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VB = 2'd1,
    S_READ    = 2'd2,
    S_WRITE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [TATTR_AW-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [7:0]          byte_q, byte_d;
  logic                vb_only_q, vb_only_d;
  logic                done_q, done_d;
  logic                abort_pend_q, abort_pend_d;

  logic busy;
  logic ctrl_wr;
  logic start_cmd;
  logic abort_cmd;
  logic dma_we;
  logic done_evt;
  logic irq_en_bit;

  assign busy      = (state_q != S_IDLE);
  assign ctrl_wr   = bus.reg_wenable && (bus.reg_addr == 2'd3);
  assign abort_cmd = ctrl_wr && bus.reg_wdata[2];
  // abort in the same write suppresses start; start while busy is dropped
  assign start_cmd = ctrl_wr && bus.reg_wdata[0] && !bus.reg_wdata[2] && !busy;

  // Next-state, counter and datapath control
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    byte_d       = byte_q;
    vb_only_d    = vb_only_q;
    done_d       = done_q;
    abort_pend_d = abort_pend_q;
    dma_we       = 1'b0;
    done_evt     = 1'b0;

    // address/length registers are writable only while idle
    if (bus.reg_wenable && !busy) begin
      case (bus.reg_addr)
        2'd0:    src_d = bus.reg_wdata[ADDR_W-1:0];
        2'd1:    dst_d = bus.reg_wdata[TATTR_AW-1:0];
        2'd2:    len_d = bus.reg_wdata[LEN_W-1:0];
        default: ;
      endcase
    end
    if (ctrl_wr) vb_only_d = bus.reg_wdata[1];

    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (start_cmd) begin
          if (len_q == '0) begin
            done_evt = 1'b1;
          end else if (bus.reg_wdata[1] && !bus.vblank) begin
            state_d = S_WAIT_VB;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_WAIT_VB: begin
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (bus.vblank) begin
          state_d = S_READ;
        end
      end

      S_READ: begin
        // the memory request cannot be withdrawn, so an abort waits for it
        if (bus.mem_ready) begin
          abort_pend_d = 1'b0;
          if (abort_cmd || abort_pend_q) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = bus.mem_rdata;
            state_d = S_WRITE;
          end
        end else if (abort_cmd) begin
          abort_pend_d = 1'b1;
        end
      end

      S_WRITE: begin
        if (abort_cmd) begin
          state_d = S_IDLE;
        end else if (!bus.cpu_tattr_we) begin
          dma_we = 1'b1;
          src_d  = src_q + ADDR_W'(1);
          dst_d  = dst_q + TATTR_AW'(1);
          len_d  = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            done_evt = 1'b1;
            state_d  = S_IDLE;
          end else if (vb_only_q && !bus.vblank) begin
            state_d = S_WAIT_VB;
          end else begin
            state_d = S_READ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (done_evt) begin
      done_d = 1'b1;
    end else if (start_cmd) begin
      done_d = 1'b0;
    end
  end

  // State and register file storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      byte_q       <= '0;
      vb_only_q    <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      byte_q       <= byte_d;
      vb_only_q    <= vb_only_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

`ifdef TATTR_DMA_IRQ_EN
  logic irq_en_q;
  logic done_irq_q;
  logic irq_en_eff;

  // a CTRL write that enables the irq and starts a zero-length copy counts
  assign irq_en_eff = ctrl_wr ? bus.reg_wdata[3] : irq_en_q;

  // Interrupt enable and one-cycle completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q   <= 1'b0;
      done_irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= bus.reg_wdata[3];
      done_irq_q <= done_evt && irq_en_eff;
    end
  end

  assign irq_en_bit   = irq_en_q;
  assign bus.done_irq = done_irq_q;
`else
  assign irq_en_bit   = 1'b0;
  assign bus.done_irq = 1'b0;
`endif

  // Register read mux; address registers return live counters
  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      2'd0:    bus.reg_rdata = 32'(src_q);
      2'd1:    bus.reg_rdata = 32'(dst_q);
      2'd2:    bus.reg_rdata = 32'(len_q);
      default: bus.reg_rdata = {28'd0, irq_en_bit, 1'b0, done_q, busy};
    endcase
  end

  assign bus.mem_req  = (state_q == S_READ);
  assign bus.mem_addr = src_q;

  // tattr port: DMA only when it actually commits, CPU otherwise
  assign bus.tattr_wenable = dma_we || bus.cpu_tattr_we;
  assign bus.tattr_addr    = dma_we ? dst_q  : bus.cpu_tattr_addr;
  assign bus.tattr_wdata   = dma_we ? byte_q : bus.cpu_tattr_wdata;

endmodule

// File: tb/tb_tattr_dma_ctrl.sv
// Testbench for tattr_dma_ctrl: table of copy jobs plus hand-written
// sequences for vblank pacing, CPU collisions, abort and reset.
module tb_tattr_dma_ctrl;

`ifdef TATTR_DMA_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready_en;

  tattr_dma_ctrl_if bus ();

  tattr_dma_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign bus.mem_ready = bus.mem_req & ready_en;
  assign bus.mem_rdata = bus.mem_req ? mem_byte(bus.mem_addr) : 8'h00;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] src;
    logic [9:0]  dst;
    logic [10:0] len;
    int          cycles;
    logic [31:0] src_end;
    logic [9:0]  dst_end;
  } vec_t;

  wr_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   wr_cnt = 0;
  int   irq_cnt = 0;
  bit   mreq_seen = 0;

  // Port monitor and scoreboard: every tattr write must match the queue head
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_req) mreq_seen = 1;
    if (bus.done_irq) irq_cnt++;
    if (bus.tattr_wenable) begin
      wr_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: write addr=%h data=%h, none expected",
                 bus.tattr_addr, bus.tattr_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e.addr !== bus.tattr_addr || e.data !== bus.tattr_wdata) begin
          fails++;
          $display("FAIL sb_write: got addr=%h data=%h expected addr=%h data=%h",
                   bus.tattr_addr, bus.tattr_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.reg_addr    = a;
    bus.reg_wdata   = d;
    bus.reg_wenable = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_wenable = 1'b0;
    bus.reg_addr    = 2'd3;
    #1;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.reg_addr = a;
    #1;
    d = bus.reg_rdata;
    bus.reg_addr = 2'd3;
    #1;
    chk(name, d, exp);
  endtask

  // Counts clock edges until busy drops; reg_addr is left at STATUS
  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (bus.reg_rdata[0] && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.reg_rdata[0]) begin
      tests++;
      fails++;
      $display("FAIL wait_idle_timeout: still busy after %0d cycles", n);
    end
  endtask

  task automatic push_job(input logic [31:0] src, input logic [9:0] dst, input int len);
    wr_t e;
    for (int k = 0; k < len; k++) begin
      e.addr = dst + 10'(k);
      e.data = mem_byte(src + 32'(k));
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[4];
    int   n, w0, irq0, seen;
    logic [31:0] st;

    vecs[0] = '{32'h0000_0100, 10'h3FE, 11'd4, 8, 32'h0000_0104, 10'h002};
    vecs[1] = '{32'h0000_2000, 10'h010, 11'd1, 2, 32'h0000_2001, 10'h011};
    vecs[2] = '{32'h0000_FFF0, 10'h3FF, 11'd3, 6, 32'h0000_FFF3, 10'h002};
    vecs[3] = '{32'h0000_0040, 10'h055, 11'd0, 0, 32'h0000_0040, 10'h055};

    bus.reg_addr        = 2'd3;
    bus.reg_wdata       = '0;
    bus.reg_wenable     = 1'b0;
    bus.cpu_tattr_addr  = '0;
    bus.cpu_tattr_wdata = '0;
    bus.cpu_tattr_we    = 1'b0;
    bus.vblank          = 1'b1;
    ready_en            = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_tattr_we", bus.tattr_wenable, 0);
    chk("rst_done_irq", bus.done_irq, 0);
    chk_reg("rst_src", 2'd0, 0);
    chk_reg("rst_dst", 2'd1, 0);
    chk_reg("rst_len", 2'd2, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_reg("rst_status", 2'd3, 0);

    reg_write(2'd3, 32'h8);
    chk_reg("irq_en_bit", 2'd3, IRQ_ON == 1 ? 32'h8 : 32'h0);

    // CPU store while idle goes straight through
    exp_q.push_back('{addr: 10'h123, data: 8'hA7});
    @(negedge clk);
    bus.cpu_tattr_we = 1'b1; bus.cpu_tattr_addr = 10'h123; bus.cpu_tattr_wdata = 8'hA7;
    @(negedge clk);
    bus.cpu_tattr_we = 1'b0;

    // table-driven copy jobs, zero-wait memory
    foreach (vecs[i]) begin
      reg_write(2'd0, vecs[i].src);
      reg_write(2'd1, 32'(vecs[i].dst));
      reg_write(2'd2, 32'(vecs[i].len));
      push_job(vecs[i].src, vecs[i].dst, int'(vecs[i].len));
      irq0 = irq_cnt;
      w0 = wr_cnt;
      mreq_seen = 0;
      reg_write(2'd3, 32'h9);
      wait_idle(200, n);
      chk($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
      chk_reg($sformatf("v%0d_status", i), 2'd3, IRQ_ON == 1 ? 32'hA : 32'h2);
      chk_reg($sformatf("v%0d_len", i), 2'd2, 0);
      chk_reg($sformatf("v%0d_src", i), 2'd0, vecs[i].src_end);
      chk_reg($sformatf("v%0d_dst", i), 2'd1, 32'(vecs[i].dst_end));
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_irq", i), irq_cnt - irq0, IRQ_ON);
      chk($sformatf("v%0d_writes", i), wr_cnt - w0, int'(vecs[i].len));
      chk($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
      if (vecs[i].len == 0) chk("len0_no_mem_req", mreq_seen, 0);
    end

    // vb_only: wait for vblank, pause after byte 2 of 5, resume
    bus.vblank = 1'b0;
    reg_write(2'd0, 32'h300);
    reg_write(2'd1, 32'h040);
    reg_write(2'd2, 32'd5);
    push_job(32'h300, 10'h040, 5);
    w0 = wr_cnt;
    mreq_seen = 0;
    reg_write(2'd3, 32'hB);
    repeat (5) @(negedge clk);
    chk("vb_wait_no_req", mreq_seen, 0);
    chk("vb_wait_busy", bus.reg_rdata[0], 1);
    bus.vblank = 1'b1;
    seen = 0;
    n = 0;
    while (seen < 2 && n < 50) begin
      @(negedge clk);
      if (bus.tattr_wenable) seen++;
      n++;
    end
    bus.vblank = 1'b0;
    chk("vb_two_bytes_seen", seen, 2);
    @(posedge clk);
    #1;
    mreq_seen = 0;
    repeat (6) @(negedge clk);
    chk("vb_pause_no_req", mreq_seen, 0);
    chk("vb_pause_writes", wr_cnt - w0, 2);
    chk("vb_pause_busy", bus.reg_rdata[0], 1);
    reg_write(2'd0, 32'hDEAD);
    chk_reg("busy_src_ignored", 2'd0, 32'h302);
    reg_write(2'd2, 32'd7);
    chk_reg("busy_len_ignored", 2'd2, 32'd3);
    bus.vblank = 1'b1;
    wait_idle(200, n);
    chk("vb_total_writes", wr_cnt - w0, 5);
    chk_reg("vb_src_end", 2'd0, 32'h305);
    chk_reg("vb_done", 2'd3, IRQ_ON == 1 ? 32'hA : 32'h2);

    // CPU store collides with the first DMA write
    reg_write(2'd0, 32'h500);
    reg_write(2'd1, 32'h020);
    reg_write(2'd2, 32'd3);
    exp_q.push_back('{addr: 10'h010, data: 8'h55});
    push_job(32'h500, 10'h020, 3);
    reg_write(2'd3, 32'h9);
    fork
      wait_idle(200, n);
      begin
        @(negedge clk);
        @(negedge clk);
        bus.cpu_tattr_we = 1'b1; bus.cpu_tattr_addr = 10'h010; bus.cpu_tattr_wdata = 8'h55;
        @(negedge clk);
        bus.cpu_tattr_we = 1'b0;
      end
    join
    chk("coll_cycles", n, 7);
    chk_reg("coll_src_end", 2'd0, 32'h503);
    chk("coll_sb_empty", exp_q.size(), 0);

    // abort while the memory read is stalled
    ready_en = 1'b0;
    reg_write(2'd0, 32'h700);
    reg_write(2'd1, 32'h080);
    reg_write(2'd2, 32'd2);
    w0 = wr_cnt;
    irq0 = irq_cnt;
    reg_write(2'd3, 32'h9);
    reg_write(2'd3, 32'hC);
    @(negedge clk);
    chk("abort_hold_req", bus.mem_req, 1);
    chk("abort_hold_busy", bus.reg_rdata[0], 1);
    @(negedge clk);
    chk("abort_hold_req2", bus.mem_req, 1);
    ready_en = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_idle_busy", bus.reg_rdata[0], 0);
    chk("abort_idle_req", bus.mem_req, 0);
    chk("abort_done", bus.reg_rdata[1], 0);
    repeat (3) @(negedge clk);
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_no_irq", irq_cnt - irq0, 0);

    // abort and start in one write: stays idle
    mreq_seen = 0;
    reg_write(2'd3, 32'hD);
    chk("abstart_busy", bus.reg_rdata[0], 0);
    repeat (3) @(negedge clk);
    chk("abstart_no_req", mreq_seen, 0);
    chk_reg("abstart_len", 2'd2, 32'd2);

    // reset mid-transfer after the first byte
    reg_write(2'd0, 32'h900);
    reg_write(2'd1, 32'h200);
    reg_write(2'd2, 32'd10);
    push_job(32'h900, 10'h200, 1);
    w0 = wr_cnt;
    reg_write(2'd3, 32'h9);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_mem_req", bus.mem_req, 0);
    chk("rstmid_tattr_we", bus.tattr_wenable, 0);
    chk("rstmid_busy", bus.reg_rdata[0], 0);
    chk_reg("rstmid_src", 2'd0, 0);
    chk_reg("rstmid_dst", 2'd1, 0);
    chk_reg("rstmid_len", 2'd2, 0);
    chk_reg("rstmid_status", 2'd3, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_writes", wr_cnt - w0, 1);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
